cbus_ram_responder: RTL and testbench
=====================================

# cbus_ram_responder

Cache-bus responder: the memory side of the `cbus_req_t`/`cbus_resp_t` protocol that DCache/ICache drive. It accepts single-beat (FIXED) and multi-beat (INCR) read/write transactions and serves them from an internal word-addressed RAM, with a programmable first-beat latency. It sits below the cache/arbiter in simulation and FPGA builds, standing in for external memory.

## Interface
- `MEM_WORDS`, 4096: RAM depth in 64-bit words; power of two.
- `LATENCY`, 2: idle cycles between request acceptance and the first beat; 0..15.
- `clk`  in  1: clock; everything on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `creq`  in  `cbus_req_t`: valid, is_write, size, addr (64), strobe (8), data (64), len, burst.
- `cresp`  out  `cbus_resp_t`: ready, last, data (64).

## Operation
- Word index: `addr[$clog2(MEM_WORDS)+2:3]`; upper bits and `addr[2:0]` are ignored. Out-of-range addresses wrap modulo MEM_WORDS.
- States: IDLE, WAIT, BEAT.
- IDLE: if `creq.valid`, latch is_write, word index, len, burst; clear beat counter. Go to WAIT if LATENCY>0, else BEAT. Latency counter loads LATENCY-1.
- WAIT: decrement the latency counter each cycle; go to BEAT when it reaches 0.
- BEAT: `cresp.ready`=1 every cycle.
  - Read: `cresp.data` = RAM[current index], combinational.
  - Write: RAM[current index] updated at the clock edge on byte lanes where `creq.strobe[i]`=1, using `creq.data`. Data and strobe are sampled live each beat, not latched.
- Beat advance: the beat counter increments each beat. With INCR, the index increments by 1 and wraps modulo MEM_WORDS. With FIXED, the index holds.
- `cresp.last`=1 on the beat where beat counter == latched len (len encoding: MLEN1=0 ... MLEN16=15). State returns to IDLE at the next edge.
- `creq.size` is not used by the RAM. Narrow reads return the full aligned word; narrow writes rely on the strobe.
- Abort: if `creq.valid`=0 in WAIT or BEAT, go to IDLE at the next edge. That cycle outputs ready=0 and performs no RAM write.
- After `last`, IDLE needs one cycle and never re-accepts in the same cycle as last. A request still valid in that IDLE cycle is treated as a new transaction.
- Reset: state to IDLE and all counters to 0. RAM contents are retained, not cleared. Reset mid-burst ends the transaction with no further writes.

## Timing
- Reset values: ready=0, last=0, data=0.
- Outside BEAT, and during write beats, `cresp.data`=0.
- `cresp.last` is only ever asserted together with `ready`.
- Request accepted at edge t (IDLE, valid=1): first ready during cycle t+1+LATENCY. Beats are consecutive with no bubbles. A len=N burst occupies N+1 ready cycles.
- Total occupancy per transaction: 1 (IDLE) + LATENCY + (len+1) cycles.
- Write data for beat k is the `creq.data` presented in the cycle ready is high for beat k.
- Initiators must hold addr, len, burst and is_write stable while valid is high. The block does not check this.

## Test plan
- Read burst, LATENCY=2: preload RAM[0x10..0x1F]=0x1000+i; read INCR len=15 at addr 0x80. Expect first ready 3 cycles after accept, data 0x1000..0x100F on consecutive cycles, last only on beat 15, then IDLE.
- Write then readback: INCR len=15 write at 0x100, data=0xA0+i, strobe=0xFF. Expect 16 ready beats with last on beat 15; a following read burst returns 0xA0..0xAF.
- Uncached narrow write: FIXED len=0 at 0x208, data=0x11223344_55667788, strobe=0x0F, over prior word 0xFFFF_FFFF_FFFF_FFFF. Expect one beat with ready=last=1; readback 0xFFFF_FFFF_5566_7788.
- Abort: drop valid after beat 5 of a 16-beat write. Expect the next cycle ready=0 and IDLE; only words 0..5 modified.
- Reset mid-burst: assert reset during beat 3 of a read. Outputs are 0 the next cycle. A new request afterwards completes normally with the same latency.
- Back-to-back with LATENCY=0: hold valid through last and present a second read. Expect one cycle with ready=0 (IDLE), then the second burst's first beat; data wraps correctly at index MEM_WORDS-1 → 0.

Source files
------------

// File: rtl/cbus_ram_responder.sv
// Cache-bus RAM responder: serves FIXED/INCR read and write bursts from an internal
// word-addressed RAM after a programmable first-beat latency.
package cbus_pkg;
  localparam logic BurstFixed = 1'b0;
  localparam logic BurstIncr  = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    logic        burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_ram_responder
  import cbus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  localparam logic [3:0] LatInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [IdxW-1:0] IdxOne = {{(IdxW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StWait, StBeat} state_e;

  state_e          state_q, state_d;
  logic            is_write_q, is_write_d;
  logic            burst_q, burst_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      beat_q, beat_d;
  logic [3:0]      lat_q, lat_d;
  logic            beat_last;
  logic            mem_we;

  logic [63:0] mem [MEM_WORDS];

  // Size, strobe-free address bits are ignored by design.
  logic unused_bits;
  assign unused_bits = ^{creq.size, creq.addr[63:IdxW+3], creq.addr[2:0]};

  assign beat_last = (beat_q == len_q);

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    burst_d    = burst_q;
    idx_d      = idx_q;
    len_d      = len_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    cresp      = '0;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (creq.valid) begin
          is_write_d = creq.is_write;
          burst_d    = creq.burst;
          idx_d      = creq.addr[IdxW+2:3];
          len_d      = creq.len;
          beat_d     = 4'd0;
          lat_d      = LatInit;
          state_d    = (LATENCY == 0) ? StBeat : StWait;
        end
      end
      StWait: begin
        if (!creq.valid) begin
          state_d = StIdle;
        end else if (lat_q == 4'd0) begin
          state_d = StBeat;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StBeat: begin
        if (!creq.valid) begin
          state_d = StIdle;
        end else begin
          cresp.ready = 1'b1;
          cresp.last  = beat_last;
          cresp.data  = is_write_q ? 64'd0 : mem[idx_q];
          // A reset landing on a write beat must not commit that beat.
          mem_we      = is_write_q && !reset;
          if (beat_last) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 4'd1;
            if (burst_q == BurstIncr) idx_d = idx_q + IdxOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      burst_q    <= 1'b0;
      idx_q      <= '0;
      len_q      <= 4'd0;
      beat_q     <= 4'd0;
      lat_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      burst_q    <= burst_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
    end
  end

  // RAM has no reset: contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (creq.strobe[i]) mem[idx_q][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Bench for cbus_ram_responder: table-driven directed transactions, corner-case sequences
// and random bursts checked against an array model of the RAM.
module tb_cbus_ram_responder;
  import cbus_pkg::*;

  localparam int Words = 64;

  logic       clk;
  logic       reset;
  cbus_req_t  creq_a  [2];
  cbus_resp_t cresp_a [2];

  int lat [2] = '{2, 0};

  int total = 0;
  int bad   = 0;

  logic [63:0] model  [2][Words];
  logic [63:0] rd_buf [16];

  cbus_ram_responder #(.MEM_WORDS(Words), .LATENCY(2)) dut0 (
    .clk  (clk),
    .reset(reset),
    .creq (creq_a[0]),
    .cresp(cresp_a[0])
  );

  cbus_ram_responder #(.MEM_WORDS(Words), .LATENCY(0)) dut1 (
    .clk  (clk),
    .reset(reset),
    .creq (creq_a[1]),
    .cresp(cresp_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1 of a cycle where the DUT is idle.
  // mode 0: full burst, 1: drop valid at beat 'at', 2: reset during beat 'at' (reads only).
  task automatic do_txn(input int d, input logic wr, input logic bst, input int len,
                        input logic [63:0] addr, input logic [63:0] base, input logic [7:0] strb,
                        input int mode, input int at, input logic rnd, input logic hold);
    int          idx;
    logic [63:0] wd;
    logic [7:0]  sb;
    idx = int'((addr >> 3) % Words);
    creq_a[d].valid    = 1'b1;
    creq_a[d].is_write = wr;
    creq_a[d].burst    = bst;
    creq_a[d].len      = 4'(len);
    creq_a[d].addr     = addr;
    creq_a[d].size     = 3'd3;
    creq_a[d].strobe   = strb;
    creq_a[d].data     = 64'd0;
    @(negedge clk);
    chk("idle_ready", 64'(cresp_a[d].ready), 64'd0);
    @(posedge clk); #1;
    for (int c = 0; c < lat[d]; c++) begin
      @(negedge clk);
      chk("wait_ready", 64'(cresp_a[d].ready), 64'd0);
      chk("wait_data", cresp_a[d].data, 64'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k <= len; k++) begin
      wd = rnd ? {$urandom(), $urandom()} : base + 64'(k);
      sb = rnd ? 8'($urandom()) : strb;
      creq_a[d].data   = wd;
      creq_a[d].strobe = sb;
      if (mode == 1 && k == at) begin
        creq_a[d].valid = 1'b0;
        @(negedge clk);
        chk("abort_ready", 64'(cresp_a[d].ready), 64'd0);
        chk("abort_last", 64'(cresp_a[d].last), 64'd0);
        @(posedge clk); #1;
        return;
      end
      if (mode == 2 && k == at) reset = 1'b1;
      @(negedge clk);
      chk("beat_ready", 64'(cresp_a[d].ready), 64'd1);
      chk("beat_last", 64'(cresp_a[d].last), 64'(k == len));
      chk(wr ? "wr_data_zero" : "rd_data", cresp_a[d].data, wr ? 64'd0 : model[d][idx]);
      if (!wr) rd_buf[k] = cresp_a[d].data;
      @(posedge clk);
      if (wr && !(mode == 2 && k == at)) begin
        for (int b = 0; b < 8; b++) if (sb[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
      #1;
      if (mode == 2 && k == at) begin
        reset = 1'b0;
        creq_a[d].valid = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 64'(cresp_a[d].ready), 64'd0);
        chk("post_reset_last", 64'(cresp_a[d].last), 64'd0);
        chk("post_reset_data", cresp_a[d].data, 64'd0);
        @(posedge clk); #1;
        return;
      end
      if (bst == BurstIncr) idx = (idx + 1) % Words;
    end
    if (!hold) creq_a[d].valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        bst;
    int          len;
    logic [63:0] addr;
    logic [63:0] base;
    logic [7:0]  strb;
    logic [63:0] exp;
    logic        exp_inc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, BurstIncr, 15, 64'h80, 64'h1000, 8'hFF, 64'h0, 1'b0};
    vecs[1] = '{1'b0, BurstIncr, 15, 64'h80, 64'h0, 8'hFF, 64'h1000, 1'b1};
    vecs[2] = '{1'b1, BurstIncr, 15, 64'h100, 64'hA0, 8'hFF, 64'h0, 1'b0};
    vecs[3] = '{1'b0, BurstIncr, 15, 64'h100, 64'h0, 8'hFF, 64'hA0, 1'b1};
    vecs[4] = '{1'b1, BurstFixed, 0, 64'h208, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b0};
    vecs[5] = '{1'b1, BurstFixed, 0, 64'h208, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 1'b0};
    vecs[6] = '{1'b0, BurstFixed, 0, 64'h208, 64'h0, 8'hFF, 64'hFFFF_FFFF_5566_7788, 1'b0};
    vecs[7] = '{1'b0, BurstFixed, 3, 64'h88, 64'h0, 8'hFF, 64'h1001, 1'b0};

    creq_a[0] = '0;
    creq_a[1] = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      chk("reset_ready", 64'(cresp_a[d].ready), 64'd0);
      chk("reset_last", 64'(cresp_a[d].last), 64'd0);
      chk("reset_data", cresp_a[d].data, 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Known contents everywhere: word i = base + i.
    for (int d = 0; d < 2; d++) begin
      for (int blk = 0; blk < 4; blk++) begin
        do_txn(d, 1'b1, BurstIncr, 15, 64'(blk * 128),
               (d == 0 ? 64'hC0DE_0000 : 64'hD00D_0000) + 64'(blk * 16),
               8'hFF, 0, 0, 1'b0, 1'b0);
      end
    end

    for (int v = 0; v < 8; v++) begin
      do_txn(0, vecs[v].wr, vecs[v].bst, vecs[v].len, vecs[v].addr, vecs[v].base, vecs[v].strb,
             0, 0, 1'b0, 1'b0);
      if (!vecs[v].wr) begin
        for (int k = 0; k <= vecs[v].len; k++)
          chk("vec_rd", rd_buf[k], vecs[v].exp + (vecs[v].exp_inc ? 64'(k) : 64'd0));
      end
    end

    // Abort after beat 5 of a 16-beat write: only words 0x30..0x35 change.
    do_txn(0, 1'b1, BurstIncr, 15, 64'h180, 64'h5000, 8'hFF, 1, 6, 1'b0, 1'b0);
    do_txn(0, 1'b0, BurstIncr, 15, 64'h180, 64'h0, 8'hFF, 0, 0, 1'b0, 1'b0);
    chk("abort_last_written", rd_buf[5], 64'h5005);
    chk("abort_untouched", rd_buf[6], 64'hC0DE_0036);

    // Reset during beat 3 of a read, then a normal request.
    do_txn(0, 1'b0, BurstIncr, 15, 64'h80, 64'h0, 8'hFF, 2, 3, 1'b0, 1'b0);
    do_txn(0, 1'b0, BurstIncr, 3, 64'h80, 64'h0, 8'hFF, 0, 0, 1'b0, 1'b0);
    chk("after_reset_rd", rd_buf[0], 64'h1000);

    // LATENCY=0 back-to-back with valid held through last, wrapping 63 -> 0.
    do_txn(1, 1'b0, BurstIncr, 3, 64'(60 * 8), 64'h0, 8'hFF, 0, 0, 1'b0, 1'b1);
    do_txn(1, 1'b0, BurstIncr, 3, 64'(62 * 8), 64'h0, 8'hFF, 0, 0, 1'b0, 1'b0);
    chk("wrap_idx0", rd_buf[2], 64'hD00D_0000);
    chk("wrap_idx1", rd_buf[3], 64'hD00D_0001);

    for (int n = 0; n < 60; n++) begin
      int          d;
      int          len;
      int          mode;
      logic        wr;
      d    = int'($urandom_range(0, 1));
      len  = int'($urandom_range(0, 15));
      wr   = 1'($urandom());
      mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
      do_txn(d, wr, 1'($urandom()), len, {$urandom(), $urandom()}, 64'h0, 8'hFF,
             mode, int'($urandom_range(0, len)), 1'b1, 1'b0);
    end

    // Confirm the random phase left both RAMs matching the model.
    for (int d = 0; d < 2; d++) begin
      for (int blk = 0; blk < 4; blk++)
        do_txn(d, 1'b0, BurstIncr, 15, 64'(blk * 128), 64'h0, 8'hFF, 0, 0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
